// File: rtl/order_book_topn.sv
// Two-sided top-of-book: routes add/cancel messages to a bid or ask book and
// keeps the best DEPTH orders per side in price-time priority.
module order_book_topn #(
   parameter int          DEPTH    = 4,
   parameter logic [7:0]  BID_CODE = 8'h42,
   parameter logic [7:0]  ASK_CODE = 8'h44,
   parameter logic [7:0]  ADD_CODE = 8'h41,
   parameter logic [7:0]  CXL_CODE = 8'h58
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [319:0]                 in_msg,
   output logic                         system_free,
   output logic [DEPTH*32-1:0]          bid_order_id,
   output logic [DEPTH*32-1:0]          bid_quantity,
   output logic [DEPTH*64-1:0]          bid_price,
   output logic [$clog2(DEPTH+1)-1:0]   bid_count,
   output logic [DEPTH*32-1:0]          ask_order_id,
   output logic [DEPTH*32-1:0]          ask_quantity,
   output logic [DEPTH*64-1:0]          ask_price,
   output logic [$clog2(DEPTH+1)-1:0]   ask_count,
   output logic [15:0]                  drop_count
);
   localparam int CW = $clog2(DEPTH+1);

   typedef enum logic {S_IDLE, S_UPDATE} state_t;

   state_t        r_state;
   logic [7:0]    r_type;
   logic [7:0]    r_side;
   logic [63:0]   r_px;
   logic [31:0]   r_qty;
   logic [31:0]   r_id;
   logic [63:0]   r_px_book  [2][DEPTH];
   logic [31:0]   r_qty_book [2][DEPTH];
   logic [31:0]   r_id_book  [2][DEPTH];
   logic [CW-1:0] r_cnt      [2];
   logic [15:0]   r_drop;

   logic          w_is_bid, w_is_ask, w_is_add, w_is_cxl, w_drop, w_sel;
   int            w_ins_pos, w_cxl_pos;
   logic [63:0]   w_px  [DEPTH];
   logic [31:0]   w_qty [DEPTH];
   logic [31:0]   w_id  [DEPTH];
   logic [CW-1:0] w_cnt;
   logic          w_unused_msg;

   assign w_unused_msg = ^{in_msg[311:152], in_msg[143:128]};

   // Next contents of the selected book (index 0 = bid, 1 = ask).
   always_comb begin
      w_is_bid  = (r_side == BID_CODE);
      w_is_ask  = (r_side == ASK_CODE);
      w_is_add  = (r_type == ADD_CODE);
      w_is_cxl  = (r_type == CXL_CODE);
      w_drop    = !(w_is_bid || w_is_ask) || !(w_is_add || w_is_cxl);
      w_sel     = w_is_ask;
      w_cnt     = r_cnt[w_sel];
      w_ins_pos = 0;
      w_cxl_pos = DEPTH;
      for (int i = 0; i < DEPTH; i++) begin
         w_px[i]  = r_px_book[w_sel][i];
         w_qty[i] = r_qty_book[w_sel][i];
         w_id[i]  = r_id_book[w_sel][i];
         if (i < int'(r_cnt[w_sel])) begin
            if (w_is_bid ? (r_px_book[w_sel][i] >= r_px) : (r_px_book[w_sel][i] <= r_px))
               w_ins_pos = w_ins_pos + 1;
            if (r_id_book[w_sel][i] == r_id && w_cxl_pos == DEPTH)
               w_cxl_pos = i;
         end
      end
      if (w_is_add && w_ins_pos < DEPTH) begin
         for (int i = 1; i < DEPTH; i++) begin
            if (i > w_ins_pos) begin
               w_px[i]  = r_px_book[w_sel][i-1];
               w_qty[i] = r_qty_book[w_sel][i-1];
               w_id[i]  = r_id_book[w_sel][i-1];
            end
         end
         for (int i = 0; i < DEPTH; i++) begin
            if (i == w_ins_pos) begin
               w_px[i]  = r_px;
               w_qty[i] = r_qty;
               w_id[i]  = r_id;
            end
         end
         if (int'(r_cnt[w_sel]) < DEPTH)
            w_cnt = r_cnt[w_sel] + CW'(1);
      end else if (w_is_cxl && w_cxl_pos < DEPTH) begin
         for (int i = 0; i < DEPTH-1; i++) begin
            if (i >= w_cxl_pos) begin
               w_px[i]  = r_px_book[w_sel][i+1];
               w_qty[i] = r_qty_book[w_sel][i+1];
               w_id[i]  = r_id_book[w_sel][i+1];
            end
         end
         // Last slot is either shifted up or is the cancelled one: always empty now.
         w_px[DEPTH-1]  = '0;
         w_qty[DEPTH-1] = '0;
         w_id[DEPTH-1]  = '0;
         w_cnt          = r_cnt[w_sel] - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_type  <= '0;
         r_side  <= '0;
         r_px    <= '0;
         r_qty   <= '0;
         r_id    <= '0;
         r_drop  <= '0;
         for (int s = 0; s < 2; s++) begin
            r_cnt[s] <= '0;
            for (int i = 0; i < DEPTH; i++) begin
               r_px_book[s][i]  <= '0;
               r_qty_book[s][i] <= '0;
               r_id_book[s][i]  <= '0;
            end
         end
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_type  <= in_msg[319:312];
                  r_side  <= in_msg[151:144];
                  r_px    <= in_msg[127:64];
                  r_qty   <= in_msg[63:32];
                  r_id    <= in_msg[31:0];
                  r_state <= S_UPDATE;
               end
            end
            S_UPDATE: begin
               if (w_drop) begin
                  if (r_drop != 16'hFFFF)
                     r_drop <= r_drop + 16'd1;
               end else begin
                  r_cnt[w_sel] <= w_cnt;
                  for (int i = 0; i < DEPTH; i++) begin
                     r_px_book[w_sel][i]  <= w_px[i];
                     r_qty_book[w_sel][i] <= w_qty[i];
                     r_id_book[w_sel][i]  <= w_id[i];
                  end
               end
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign in_ready    = (r_state == S_IDLE);
   assign system_free = (r_state == S_IDLE);
   assign bid_count   = r_cnt[0];
   assign ask_count   = r_cnt[1];
   assign drop_count  = r_drop;

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
         assign bid_price[64*gi +: 64]    = r_px_book[0][gi];
         assign bid_quantity[32*gi +: 32] = r_qty_book[0][gi];
         assign bid_order_id[32*gi +: 32] = r_id_book[0][gi];
         assign ask_price[64*gi +: 64]    = r_px_book[1][gi];
         assign ask_quantity[32*gi +: 32] = r_qty_book[1][gi];
         assign ask_order_id[32*gi +: 32] = r_id_book[1][gi];
      end
   endgenerate
endmodule

// File: tb/tb_order_book_topn.sv
// Randomized bench for order_book_topn against a queue-based book model.
module tb_order_book_topn;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH+1);

   logic                clk = 1'b0;
   logic                reset;
   logic                in_valid;
   logic                in_ready;
   logic [319:0]        in_msg;
   logic                system_free;
   logic [DEPTH*32-1:0] bid_order_id, bid_quantity, ask_order_id, ask_quantity;
   logic [DEPTH*64-1:0] bid_price, ask_price;
   logic [CW-1:0]       bid_count, ask_count;
   logic [15:0]         drop_count;

   order_book_topn #(.DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_msg(in_msg), .system_free(system_free),
      .bid_order_id(bid_order_id), .bid_quantity(bid_quantity), .bid_price(bid_price),
      .bid_count(bid_count), .ask_order_id(ask_order_id), .ask_quantity(ask_quantity),
      .ask_price(ask_price), .ask_count(ask_count), .drop_count(drop_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] px;
      logic [31:0] qty;
      logic [31:0] id;
   } ord_t;

   ord_t bq[$];
   ord_t aq[$];
   int   m_drop;
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [319:0] mk(input logic [7:0] t, input logic [7:0] s,
                                       input logic [63:0] px, input logic [31:0] q,
                                       input logic [31:0] id);
      logic [319:0] m;
      for (int w = 0; w < 10; w++) m[32*w +: 32] = $urandom;
      m[319:312] = t;
      m[151:144] = s;
      m[127:64]  = px;
      m[63:32]   = q;
      m[31:0]    = id;
      return m;
   endfunction

   task automatic model_apply(input logic [319:0] m);
      logic [7:0] t, s;
      logic       bid;
      int         p;
      ord_t       q[$];
      ord_t       o;
      t   = m[319:312];
      s   = m[151:144];
      bid = (s == 8'h42);
      if (!(s == 8'h42 || s == 8'h44) || !(t == 8'h41 || t == 8'h58)) begin
         if (m_drop < 65535) m_drop++;
         return;
      end
      if (bid) q = bq; else q = aq;
      if (t == 8'h41) begin
         p = 0;
         foreach (q[i]) if (bid ? (q[i].px >= m[127:64]) : (q[i].px <= m[127:64])) p++;
         if (p < DEPTH) begin
            o.px = m[127:64]; o.qty = m[63:32]; o.id = m[31:0];
            q.insert(p, o);
            if (q.size() > DEPTH) void'(q.pop_back());
         end
      end else begin
         for (int i = 0; i < q.size(); i++) begin
            if (q[i].id == m[31:0]) begin
               q.delete(i);
               break;
            end
         end
      end
      if (bid) bq = q; else aq = q;
   endtask

   task automatic check_books(input string ctx);
      ord_t eb, ea;
      for (int k = 0; k < DEPTH; k++) begin
         eb = '{px: 64'd0, qty: 32'd0, id: 32'd0};
         ea = eb;
         if (k < bq.size()) eb = bq[k];
         if (k < aq.size()) ea = aq[k];
         check_eq($sformatf("%s bid_px[%0d]", ctx, k),  bid_price[64*k +: 64],    eb.px);
         check_eq($sformatf("%s bid_qty[%0d]", ctx, k), bid_quantity[32*k +: 32], {32'd0, eb.qty});
         check_eq($sformatf("%s bid_id[%0d]", ctx, k),  bid_order_id[32*k +: 32], {32'd0, eb.id});
         check_eq($sformatf("%s ask_px[%0d]", ctx, k),  ask_price[64*k +: 64],    ea.px);
         check_eq($sformatf("%s ask_qty[%0d]", ctx, k), ask_quantity[32*k +: 32], {32'd0, ea.qty});
         check_eq($sformatf("%s ask_id[%0d]", ctx, k),  ask_order_id[32*k +: 32], {32'd0, ea.id});
      end
      check_eq({ctx, " bid_count"}, 64'(bid_count), 64'(bq.size()));
      check_eq({ctx, " ask_count"}, 64'(ask_count), 64'(aq.size()));
      check_eq({ctx, " drop_count"}, 64'(drop_count), 64'(m_drop));
   endtask

   task automatic do_reset();
      reset    = 1'b1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      bq.delete();
      aq.delete();
      m_drop = 0;
   endtask

   task automatic send(input logic [319:0] m);
      @(negedge clk);
      check_eq("ready_idle", 64'(in_ready), 64'd1);
      in_valid = 1'b1;
      in_msg   = m;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_msg   = {10{$urandom}};
      check_eq("ready_busy", 64'(in_ready), 64'd0);
      check_eq("free_busy", 64'(system_free), 64'd0);
      @(posedge clk);
      #1;
      model_apply(m);
      check_books("msg");
      $display("[TB] msg type=%h side=%h px=%0d id=%0d -> bid_cnt=%0d ask_cnt=%0d drops=%0d",
               m[319:312], m[151:144], m[127:64], m[31:0], bid_count, ask_count, drop_count);
   endtask

   logic [319:0] hm;
   logic [7:0]   rt, rs;
   int           r;

   initial begin
      in_msg = '0;
      do_reset();
      check_books("reset");
      check_eq("reset in_ready", 64'(in_ready), 64'd1);
      check_eq("reset system_free", 64'(system_free), 64'd1);

      send(mk(8'h41, 8'h42, 64'd100, 32'd5, 32'd1));
      send(mk(8'h41, 8'h42, 64'd300, 32'd6, 32'd2));
      send(mk(8'h41, 8'h42, 64'd200, 32'd7, 32'd3));
      check_eq("plan bid_px0", bid_price[63:0], 64'd300);
      check_eq("plan bid_id1", 64'(bid_order_id[63:32]), 64'd3);
      send(mk(8'h41, 8'h44, 64'd500, 32'd1, 32'd10));
      send(mk(8'h41, 8'h44, 64'd400, 32'd2, 32'd11));
      send(mk(8'h41, 8'h44, 64'd400, 32'd3, 32'd12));
      check_eq("plan ask_id1", 64'(ask_order_id[63:32]), 64'd12);
      send(mk(8'h58, 8'h42, 64'd999, 32'd9, 32'd3));
      check_eq("plan cxl bid_px1", bid_price[127:64], 64'd100);
      send(mk(8'h58, 8'h42, 64'd0, 32'd0, 32'd77));
      send(mk(8'h41, 8'h55, 64'd10, 32'd1, 32'd40));
      send(mk(8'h51, 8'h42, 64'd10, 32'd1, 32'd41));
      check_eq("plan drop2", 64'(drop_count), 64'd2);

      // in_valid held high: one accept every other cycle.
      hm = mk(8'h41, 8'h55, 64'd1, 32'd1, 32'd1);
      @(negedge clk);
      in_valid = 1'b1;
      in_msg   = hm;
      check_eq("held rdy0", 64'(in_ready), 64'd1);
      @(negedge clk);
      check_eq("held rdy1", 64'(in_ready), 64'd0);
      @(negedge clk);
      check_eq("held rdy2", 64'(in_ready), 64'd1);
      @(negedge clk);
      check_eq("held rdy3", 64'(in_ready), 64'd0);
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      model_apply(hm);
      model_apply(hm);
      check_books("held");
      $display("[TB] held in_valid: two drops, drops=%0d", drop_count);

      // Full bid book boundaries.
      do_reset();
      send(mk(8'h41, 8'h42, 64'd300, 32'd1, 32'd1));
      send(mk(8'h41, 8'h42, 64'd200, 32'd1, 32'd2));
      send(mk(8'h41, 8'h42, 64'd150, 32'd1, 32'd3));
      send(mk(8'h41, 8'h42, 64'd100, 32'd1, 32'd4));
      send(mk(8'h41, 8'h42, 64'd50,  32'd1, 32'd5));
      check_eq("full discard count", 64'(bid_count), 64'd4);
      send(mk(8'h41, 8'h42, 64'd250, 32'd1, 32'd9));
      check_eq("full evict px3", bid_price[255:192], 64'd150);
      send(mk(8'h41, 8'h42, 64'd150, 32'd2, 32'd8));

      // Reset during UPDATE aborts the pending add.
      @(negedge clk);
      in_valid = 1'b1;
      in_msg   = mk(8'h41, 8'h44, 64'd77, 32'd7, 32'd7);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      reset    = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      bq.delete();
      aq.delete();
      m_drop = 0;
      check_books("rst_upd");
      check_eq("rst_upd in_ready", 64'(in_ready), 64'd1);
      check_eq("rst_upd free", 64'(system_free), 64'd1);
      $display("[TB] reset in UPDATE: bid_cnt=%0d ask_cnt=%0d", bid_count, ask_count);

      // Random traffic with narrow price/id ranges to force ties, evictions and cancels.
      for (int n = 0; n < 300; n++) begin
         r  = int'($urandom_range(0, 99));
         rt = (r < 50) ? 8'h41 : (r < 88) ? 8'h58 : 8'($urandom);
         r  = int'($urandom_range(0, 99));
         rs = (r < 46) ? 8'h42 : (r < 92) ? 8'h44 : 8'($urandom);
         send(mk(rt, rs, 64'($urandom_range(0, 7)) * 64'd1000, $urandom, 32'($urandom_range(0, 11))));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
